// File: rtl/tta_dmem_responder_pkg.sv
// Shared definitions for the TTA data-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tta_mem_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 22;
  localparam int MEM_ADDR_W_DEF = 10;

  // mem_en_x, wr_en_x and wr_mask_x are all asserted at this level.
  localparam logic ACT_LO = 1'b0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/tta_dmem_responder_sram_1p.sv
// Single-port, bit-maskable word storage with a registered read port.
// Latency: read data appears on rdata one cycle after an enabled read.
// Backpressure: none; every enabled cycle is serviced, rdata holds otherwise.
module tta_sram_1p #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [DATA_W-1:0] bitmask,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<IDX_W)-1];

  // Masked write or registered read; contents and rdata are not reset, like the macro.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= (mem[idx] & ~bitmask) | (wdata & bitmask);
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/tta_dmem_responder.sv
// Memory end of the TTA LSU port: range decode, sticky error, wait-state stall FSM.
// Latency: read data valid the cycle after acceptance; writes commit at acceptance.
// Backpressure: after each access glock_req stalls the core for WAIT_STATES cycles; requests are ignored meanwhile.
module tta_dmem_responder
  import tta_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MEM_ADDR_W  = MEM_ADDR_W_DEF,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_out,
  input  logic              mem_en_x,
  input  logic              wr_en_x,
  input  logic [DATA_W-1:0] wr_mask_x,
  output logic [DATA_W-1:0] data_in,
  output logic              glock_req,
  output logic              err
);

  state_e            state;
  logic [3:0]        cnt;
  logic              accept;
  logic              is_wr;
  logic              in_range;
  logic              rd_zero;
  logic [DATA_W-1:0] sram_rdata;

  // An access is taken only in IDLE and never while reset is asserted.
  always_comb begin
    accept   = reset && (state == S_IDLE) && (mem_en_x == ACT_LO);
    is_wr    = (wr_en_x == ACT_LO);
    in_range = (addr[ADDR_W-1:MEM_ADDR_W] == '0);
  end

  tta_sram_1p #(
    .DATA_W (DATA_W),
    .IDX_W  (MEM_ADDR_W)
  ) u_sram (
    .clk     (clk),
    .en      (accept && in_range),
    .we      (is_wr),
    .bitmask (~wr_mask_x),
    .idx     (addr[MEM_ADDR_W-1:0]),
    .wdata   (data_out),
    .rdata   (sram_rdata)
  );

  // rd_zero forces data_in to 0 after reset and after an out-of-range read;
  // the SRAM read register is untouched by those, so it is masked instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_zero <= 1'b1;
    end else if (accept && !is_wr) begin
      rd_zero <= !in_range;
    end
  end

  assign data_in = rd_zero ? '0 : sram_rdata;

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (accept && !in_range) begin
      err <= 1'b1;
    end
  end

  // Wait-state FSM: glock_req is high for exactly WAIT_STATES cycles after each accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      glock_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && (WAIT_STATES != 0)) begin
            state     <= S_WAIT;
            cnt       <= 4'(WAIT_STATES);
            glock_req <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            glock_req <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          glock_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tta_dmem_responder.sv
// Bench for tta_dmem_responder: one instance with no wait states, one with three.
// Read expectations are queued at issue time and popped by per-instance monitors.
// Stall, error and reset behaviour are checked inline at fixed cycle offsets.
module tb_tta_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0: WAIT_STATES = 0
  logic        rst0, men0, wen0;
  logic [21:0] addr0;
  logic [31:0] dout0, mask0, di0;
  logic        gl0, err0;

  // Instance 3: WAIT_STATES = 3
  logic        rst3, men3, wen3;
  logic [21:0] addr3;
  logic [31:0] dout3, mask3, di3;
  logic        gl3, err3;

  logic [31:0] q0[$];
  logic [31:0] q3[$];
  logic        acc_rd0 = 1'b0;
  logic        acc_rd3 = 1'b0;
  logic        rd3_mark = 1'b0;

  tta_dmem_responder #(.DATA_W(32), .ADDR_W(22), .MEM_ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst0), .addr(addr0), .data_out(dout0), .mem_en_x(men0),
    .wr_en_x(wen0), .wr_mask_x(mask0), .data_in(di0), .glock_req(gl0), .err(err0)
  );

  tta_dmem_responder #(.DATA_W(32), .ADDR_W(22), .MEM_ADDR_W(10), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(rst3), .addr(addr3), .data_out(dout3), .mem_en_x(men3),
    .wr_en_x(wen3), .wr_mask_x(mask3), .data_in(di3), .glock_req(gl3), .err(err3)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Instance 0 is always IDLE, so any presented read is accepted.
  always @(posedge clk) acc_rd0 <= rst0 && !men0 && wen0;
  always @(posedge clk) acc_rd3 <= rd3_mark;

  // Monitor 0: compare read data against the queue; glock must never rise.
  always @(negedge clk) begin
    check("glock0_const", {31'd0, gl0}, 32'd0);
    if (acc_rd0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd0_underflow actual=read_seen expected=no_read");
      end else begin
        check("rd0_data", di0, q0.pop_front());
      end
    end
  end

  // Monitor 3
  always @(negedge clk) begin
    if (acc_rd3) begin
      if (q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd3_underflow actual=read_seen expected=no_read");
      end else begin
        check("rd3_data", di3, q3.pop_front());
      end
    end
  end

  task automatic acc0(input logic wr, input logic [21:0] a, input logic [31:0] d,
                      input logic [31:0] m, input logic [31:0] exp);
    men0 = 1'b0; wen0 = !wr; addr0 = a; dout0 = d; mask0 = m;
    if (!wr) q0.push_back(exp);
    @(posedge clk); #1;
    men0 = 1'b1;
  endtask

  // One access on instance 3, then verify the 3-cycle stall window.
  task automatic acc3(input logic wr, input logic [21:0] a, input logic [31:0] d,
                      input logic [31:0] m, input logic [31:0] exp);
    men3 = 1'b0; wen3 = !wr; addr3 = a; dout3 = d; mask3 = m;
    rd3_mark = !wr;
    if (!wr) q3.push_back(exp);
    @(posedge clk); #1;
    men3 = 1'b1; rd3_mark = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("glock3_high", {31'd0, gl3}, 32'd1);
    end
    @(negedge clk);
    check("glock3_drop", {31'd0, gl3}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b0; men0 = 1'b1; wen0 = 1'b1; addr0 = '0; dout0 = '0; mask0 = '1;
    rst3 = 1'b0; men3 = 1'b1; wen3 = 1'b1; addr3 = '0; dout3 = '0; mask3 = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data0", di0, 32'd0);
    check("rst_err0", {31'd0, err0}, 32'd0);
    check("rst_data3", di3, 32'd0);
    check("rst_glock3", {31'd0, gl3}, 32'd0);
    check("rst_err3", {31'd0, err3}, 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b1; rst3 = 1'b1;

    // ---------------- instance 0 ----------------
    acc0(1'b1, 22'h005, 32'hDEADBEEF, 32'h00000000, '0);
    acc0(1'b0, 22'h005, '0, '1, 32'hDEADBEEF);
    acc0(1'b1, 22'h005, 32'h0000AA00, 32'hFFFF00FF, '0);
    acc0(1'b0, 22'h005, '0, '1, 32'hDEADAAEF);
    @(negedge clk);
    check("hold_idle0", di0, 32'hDEADAAEF);
    @(posedge clk); #1;
    // back-to-back same address
    acc0(1'b1, 22'h010, 32'h11111111, 32'h00000000, '0);
    acc0(1'b0, 22'h010, '0, '1, 32'h11111111);
    acc0(1'b1, 22'h010, 32'h22223333, 32'h00000000, '0);
    acc0(1'b0, 22'h010, '0, '1, 32'h22223333);
    acc0(1'b1, 22'h3FF, 32'hA5A5A5A5, 32'h00000000, '0);
    acc0(1'b1, 22'h000, 32'hCAFEF00D, 32'h00000000, '0);
    acc0(1'b0, 22'h3FF, '0, '1, 32'hA5A5A5A5);
    @(negedge clk);
    check("err0_before_oor", {31'd0, err0}, 32'd0);
    @(posedge clk); #1;
    acc0(1'b0, 22'h000400, '0, '1, 32'h00000000);
    @(negedge clk);
    check("err0_set", {31'd0, err0}, 32'd1);
    @(posedge clk); #1;
    acc0(1'b1, 22'h000400, 32'h12345678, 32'h00000000, '0);
    acc0(1'b0, 22'h000, '0, '1, 32'hCAFEF00D);
    acc0(1'b1, 22'h020, 32'h0BADF00D, 32'h00000000, '0);
    @(negedge clk);
    check("hold_over_write0", di0, 32'hCAFEF00D);
    check("err0_sticky", {31'd0, err0}, 32'd1);
    @(posedge clk); #1;

    // ---------------- instance 3 ----------------
    acc3(1'b1, 22'h007, 32'h13579BDF, 32'h00000000, '0);
    // read, with request pulses held low through the stall
    men3 = 1'b0; wen3 = 1'b1; addr3 = 22'h007; rd3_mark = 1'b1;
    q3.push_back(32'h13579BDF);
    @(posedge clk); #1;
    rd3_mark = 1'b0;
    men3 = 1'b0; wen3 = 1'b0; dout3 = 32'hFFFFFFFF; mask3 = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_glock3", {31'd0, gl3}, 32'd1);
      check("stall_data3", di3, 32'h13579BDF);
    end
    @(posedge clk); #1;
    men3 = 1'b1;
    @(negedge clk);
    check("stall_end3", {31'd0, gl3}, 32'd0);
    // the write pulses during the stall must not have landed
    acc3(1'b0, 22'h007, '0, '1, 32'h13579BDF);
    acc3(1'b0, 22'h3FF000, '0, '1, 32'h00000000);
    check("err3_set", {31'd0, err3}, 32'd1);
    // reset in the first stall cycle
    men3 = 1'b0; wen3 = 1'b1; addr3 = 22'h007; rd3_mark = 1'b1;
    q3.push_back(32'h13579BDF);
    @(posedge clk); #1;
    rd3_mark = 1'b0; men3 = 1'b1; rst3 = 1'b0;
    @(negedge clk);
    check("pre_rst_glock3", {31'd0, gl3}, 32'd1);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(negedge clk);
    check("midrst_glock3", {31'd0, gl3}, 32'd0);
    check("midrst_data3", di3, 32'd0);
    check("midrst_err3", {31'd0, err3}, 32'd0);
    @(negedge clk);
    check("midrst_idle3", {31'd0, gl3}, 32'd0);
    @(posedge clk); #1;
    acc3(1'b0, 22'h007, '0, '1, 32'h13579BDF);

    repeat (3) @(negedge clk);
    check("drain_q0", q0.size(), 32'd0);
    check("drain_q3", q3.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
